exception_arbiter: RTL

//  MEM-stage exception collector directly upstream of the CP0 register file. Merges per-stage

---
 rtl/exception_arbiter_if.sv | 56 +++++
 rtl/exception_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/exception_arbiter_if.sv
// Signal bundle between the MEM-stage pipeline/CP0 glue and exception_arbiter.
// TIMER_INT_EN adds the timer_int_i line.
interface exception_arbiter_if;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic        adel_if_i;
   logic        ri_i;
   logic        syscall_i;
   logic        break_i;
   logic        eret_i;
   logic        ov_i;
   logic        adel_mem_i;
   logic        ades_mem_i;
   logic [31:0] mem_addr_i;
   logic [31:0] cp0_status_i;
   logic [31:0] cp0_cause_i;
   logic [31:0] cp0_epc_i;
   logic        wb_cp0_we_i;
   logic [4:0]  wb_cp0_waddr_i;
   logic [31:0] wb_cp0_data_i;
   logic        bus_busy_i;
`ifdef TIMER_INT_EN
   logic        timer_int_i;
`endif
   logic        mem_kill_o;
   logic        stall_o;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;
   logic        flush_o;
   logic [31:0] newpc_o;

   modport master (
      output mem_valid_i, mem_pc_i, mem_in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
             eret_i, ov_i, adel_mem_i, ades_mem_i, mem_addr_i, cp0_status_i, cp0_cause_i,
             cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i, bus_busy_i,
`ifdef TIMER_INT_EN
             timer_int_i,
`endif
      input  mem_kill_o, stall_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, newpc_o
   );

   modport slave (
      input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, adel_if_i, ri_i, syscall_i, break_i,
             eret_i, ov_i, adel_mem_i, ades_mem_i, mem_addr_i, cp0_status_i, cp0_cause_i,
             cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i, bus_busy_i,
`ifdef TIMER_INT_EN
             timer_int_i,
`endif
      output mem_kill_o, stall_o, excepttype_o, current_inst_addr_o, is_in_delayslot_o,
             bad_addr_o, flush_o, newpc_o
   );
endinterface

// File: rtl/exception_arbiter.sv
// MEM-stage exception collector: prioritises exceptions, drains the data bus, commits to CP0.
// Define TIMER_INT_EN to OR timer_int_i into Cause IP7 for interrupt detection.
module exception_arbiter #(
   parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
   parameter int unsigned IP_W      = 8
) (
   input logic              clk,
   input logic              rst,
   exception_arbiter_if.slave bus
);

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   localparam logic [31:0] CODE_INT  = 32'h01;
   localparam logic [31:0] CODE_ADEL = 32'h04;
   localparam logic [31:0] CODE_ADES = 32'h05;
   localparam logic [31:0] CODE_SYS  = 32'h08;
   localparam logic [31:0] CODE_BP   = 32'h09;
   localparam logic [31:0] CODE_RI   = 32'h0a;
   localparam logic [31:0] CODE_OV   = 32'h0c;
   localparam logic [31:0] CODE_ERET = 32'h0e;

   typedef enum logic [1:0] {StIdle, StDrain, StCommit} state_e;

   state_e      state_q, state_d;
   logic [31:0] code_q, code_d;
   logic [31:0] pc_q, pc_d;
   logic        ds_q, ds_d;
   logic [31:0] bad_q, bad_d;
   logic [31:0] newpc_q, newpc_d;

   // Effective CP0 view: an mtc0 retiring in WB this cycle wins over the register file.
   logic            wr_status, wr_cause, wr_epc;
   logic            status_ie, status_exl;
   logic [IP_W-1:0] status_im, cause_ip;
   logic [31:0]     epc_eff;
   logic            int_pend;

   always_comb begin
      wr_status  = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == REG_STATUS);
      wr_cause   = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == REG_CAUSE);
      wr_epc     = bus.wb_cp0_we_i && (bus.wb_cp0_waddr_i == REG_EPC);
      status_ie  = wr_status ? bus.wb_cp0_data_i[0] : bus.cp0_status_i[0];
      status_exl = wr_status ? bus.wb_cp0_data_i[1] : bus.cp0_status_i[1];
      status_im  = wr_status ? bus.wb_cp0_data_i[8 +: IP_W] : bus.cp0_status_i[8 +: IP_W];
      cause_ip   = wr_cause ? bus.wb_cp0_data_i[8 +: IP_W] : bus.cp0_cause_i[8 +: IP_W];
`ifdef TIMER_INT_EN
      cause_ip[IP_W-1] = cause_ip[IP_W-1] | bus.timer_int_i;
`endif
      epc_eff    = wr_epc ? bus.wb_cp0_data_i : bus.cp0_epc_i;
      int_pend   = status_ie & ~status_exl & (|(cause_ip & status_im));
   end

   logic [31:0] code_sel;
   logic [31:0] bad_sel;

   always_comb begin
      code_sel = '0;
      bad_sel  = '0;
      if (int_pend) begin
         code_sel = CODE_INT;
      end else if (bus.adel_if_i) begin
         code_sel = CODE_ADEL;
         bad_sel  = bus.mem_pc_i;
      end else if (bus.ri_i) begin
         code_sel = CODE_RI;
      end else if (bus.ov_i) begin
         code_sel = CODE_OV;
      end else if (bus.syscall_i) begin
         code_sel = CODE_SYS;
      end else if (bus.break_i) begin
         code_sel = CODE_BP;
      end else if (bus.adel_mem_i) begin
         code_sel = CODE_ADEL;
         bad_sel  = bus.mem_addr_i;
      end else if (bus.ades_mem_i) begin
         code_sel = CODE_ADES;
         bad_sel  = bus.mem_addr_i;
      end else if (bus.eret_i) begin
         code_sel = CODE_ERET;
      end
   end

   logic detect;

   always_comb begin
      detect  = ~rst && (state_q == StIdle) && bus.mem_valid_i && (code_sel != '0);
      state_d = state_q;
      code_d  = code_q;
      pc_d    = pc_q;
      ds_d    = ds_q;
      bad_d   = bad_q;
      newpc_d = newpc_q;

      bus.mem_kill_o          = 1'b0;
      bus.stall_o             = 1'b0;
      bus.flush_o             = 1'b0;
      bus.excepttype_o        = '0;
      bus.current_inst_addr_o = pc_q;
      bus.is_in_delayslot_o   = ds_q;
      bus.bad_addr_o          = bad_q;
      bus.newpc_o             = newpc_q;

      unique case (state_q)
         StIdle: begin
            if (detect) begin
               code_d         = code_sel;
               pc_d           = bus.mem_pc_i;
               ds_d           = bus.mem_in_delayslot_i;
               bad_d          = bad_sel;
               newpc_d        = (code_sel == CODE_ERET) ? epc_eff : EXC_ENTRY;
               bus.mem_kill_o = 1'b1;
               bus.stall_o    = 1'b1;
               state_d        = bus.bus_busy_i ? StDrain : StCommit;
            end
         end
         StDrain: begin
            bus.stall_o = 1'b1;
            if (!bus.bus_busy_i) state_d = StCommit;
         end
         StCommit: begin
            bus.excepttype_o = code_q;
            bus.flush_o      = 1'b1;
            state_d          = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         code_q  <= '0;
         pc_q    <= '0;
         ds_q    <= 1'b0;
         bad_q   <= '0;
         newpc_q <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pc_q    <= pc_d;
         ds_q    <= ds_d;
         bad_q   <= bad_d;
         newpc_q <= newpc_d;
      end
   end

endmodule
